// File: rtl/uart_mmio_ctrl.sv
// uart_mmio_ctrl: memory-mapped UART byte bridge for the CPU.
//
// Decodes CPU loads/stores in the 0x8xxxxxxx region (word offset addr[4:2]) and
// moves bytes through a TX FIFO (CPU -> UART) and an RX FIFO (UART -> CPU).
//
//   offset 0 (0x80000000) R : RX status {30'b0, rx_overrun, rx_not_empty}, read clears overrun
//   offset 1 (0x80000004) R : TX status {30'b0, tx_overflow, tx_not_full}, read clears overflow
//   offset 2 (0x80000008) W : TX data push (dropped and flagged when full)
//   offset 3 (0x8000000C) R : RX data pop ({24'b0, byte}, 0 when empty)
//   offset 4 (0x80000010) R : cycle counter (only with UART_MMIO_CYCLE_COUNTER_EN)
//   offset 6 (0x80000018) W : clear cycle counter (only with UART_MMIO_CYCLE_COUNTER_EN)
//
// Optional feature macro: UART_MMIO_CYCLE_COUNTER_EN (undefined by default).
//
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   stall                       : CPU stall, blocks all CPU accesses
//   addr, wdata, wr_en, rd_en   : CPU access
//   rdata                       : registered load data
//   uart_din/_valid/_ready      : TX byte handshake toward the UART
//   uart_dout/_valid/_ready     : RX byte handshake from the UART

module uart_mmio_ctrl #(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [31:0] addr,
  input  logic [7:0]  wdata,
  input  logic        wr_en,
  input  logic        rd_en,
  output logic [31:0] rdata,
  output logic [7:0]  uart_din,
  output logic        uart_din_valid,
  input  logic        uart_din_ready,
  input  logic [7:0]  uart_dout,
  input  logic        uart_dout_valid,
  output logic        uart_dout_ready
);

  localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
  localparam int unsigned PtrW  = AddrW + 1;

  // CPU decode
  logic       sel, ld, st;
  logic [2:0] offset;
  logic       unused_addr;

  assign sel         = (addr[31:28] == 4'h8) && !stall;
  assign offset      = addr[4:2];
  assign ld          = sel && rd_en;
  assign st          = sel && wr_en;
  assign unused_addr = ^{addr[27:5], addr[1:0]};

  // TX FIFO
  logic [7:0]      tx_mem [FIFO_DEPTH];
  logic [PtrW-1:0] tx_wptr_q, tx_rptr_q;
  logic            tx_empty, tx_full, tx_pop, tx_wr, tx_push;
  logic            tx_ovf_q, tx_ovf_d;

  assign tx_empty = (tx_wptr_q == tx_rptr_q);
  assign tx_full  = (tx_wptr_q[PtrW-1] != tx_rptr_q[PtrW-1]) &&
                    (tx_wptr_q[AddrW-1:0] == tx_rptr_q[AddrW-1:0]);

  assign uart_din_valid = !tx_empty;
  assign uart_din       = tx_mem[tx_rptr_q[AddrW-1:0]];

  assign tx_pop  = !tx_empty && uart_din_ready;
  assign tx_wr   = st && (offset == 3'd2);
  // A full FIFO still accepts the byte when the UART frees a slot on this edge.
  assign tx_push = tx_wr && (!tx_full || tx_pop);

  // RX FIFO
  logic [7:0]      rx_mem [FIFO_DEPTH];
  logic [PtrW-1:0] rx_wptr_q, rx_rptr_q;
  logic            rx_empty, rx_full, rx_pop, rx_push;
  logic            rx_ovr_q, rx_ovr_d;

  assign rx_empty = (rx_wptr_q == rx_rptr_q);
  assign rx_full  = (rx_wptr_q[PtrW-1] != rx_rptr_q[PtrW-1]) &&
                    (rx_wptr_q[AddrW-1:0] == rx_rptr_q[AddrW-1:0]);

  assign rx_pop = ld && (offset == 3'd3) && !rx_empty;
  // A CPU pop on this edge frees a slot, so a full FIFO can still take a byte.
  assign uart_dout_ready = !rx_full || rx_pop;
  assign rx_push         = uart_dout_valid && uart_dout_ready;

  // Sticky bits: a set on the same edge as the clearing read wins.
  always_comb begin
    tx_ovf_d = tx_ovf_q;
    rx_ovr_d = rx_ovr_q;
    if (ld && (offset == 3'd1)) tx_ovf_d = 1'b0;
    if (ld && (offset == 3'd0)) rx_ovr_d = 1'b0;
    if (tx_wr && !tx_push) tx_ovf_d = 1'b1;
    if (uart_dout_valid && !uart_dout_ready) rx_ovr_d = 1'b1;
  end

`ifdef UART_MMIO_CYCLE_COUNTER_EN
  logic [31:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 32'd0;
    end else if (st && (offset == 3'd6)) begin
      cnt_q <= 32'd0;
    end else begin
      cnt_q <= cnt_q + 32'd1;
    end
  end
`endif

  // Load data
  logic [31:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (ld) begin
      case (offset)
        3'd0:    rdata_d = {30'd0, rx_ovr_q, !rx_empty};
        3'd1:    rdata_d = {30'd0, tx_ovf_q, !tx_full};
        3'd3:    rdata_d = rx_empty ? 32'd0 : {24'd0, rx_mem[rx_rptr_q[AddrW-1:0]]};
`ifdef UART_MMIO_CYCLE_COUNTER_EN
        3'd4:    rdata_d = cnt_q;
`endif
        default: rdata_d = 32'd0;
      endcase
    end
  end

  assign rdata = rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      tx_ovf_q  <= 1'b0;
      rx_ovr_q  <= 1'b0;
      rdata_q   <= 32'd0;
    end else begin
      tx_ovf_q <= tx_ovf_d;
      rx_ovr_q <= rx_ovr_d;
      rdata_q  <= rdata_d;
      if (tx_push) begin
        tx_mem[tx_wptr_q[AddrW-1:0]] <= wdata;
        tx_wptr_q <= tx_wptr_q + PtrW'(1);
      end
      if (tx_pop) tx_rptr_q <= tx_rptr_q + PtrW'(1);
      if (rx_push) begin
        rx_mem[rx_wptr_q[AddrW-1:0]] <= uart_dout;
        rx_wptr_q <= rx_wptr_q + PtrW'(1);
      end
      if (rx_pop) rx_rptr_q <= rx_rptr_q + PtrW'(1);
    end
  end

endmodule

// File: doc/uart_mmio_ctrl.md
UART_MMIO_CTRL -- requirements
Module: uart_mmio_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8: entries per TX and RX FIFO; must be a power of 2, at least 2.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port stall, input, 1: CPU pipeline stall; when high, CPU accesses are ignored.
REQ-005 SHALL have port addr, input, 32: CPU access address (stage-Y ALU result).
REQ-006 SHALL have port wdata, input, 8: CPU store data (RT[7:0]).
REQ-007 SHALL have port wr_en, input, 1: CPU store strobe.
REQ-008 SHALL have port rd_en, input, 1: CPU load strobe.
REQ-009 SHALL have port rdata, output, 32: registered load data, consumed in stage Z.
REQ-010 SHALL have ports uart_din (output, 8), uart_din_valid (output, 1) and uart_din_ready (input, 1): TX byte handshake to the UART.
REQ-011 SHALL have ports uart_dout (input, 8), uart_dout_valid (input, 1) and uart_dout_ready (output, 1): RX byte handshake from the UART.

Function
REQ-012 SHALL decode an access only when addr[31:28]==4'h8 and stall==0; the word offset is addr[4:2], and addr[1:0] are ignored.
REQ-013 SHALL map offset 0 (0x80000000, read) to RX status: bit0 = RX FIFO not empty, bit1 = RX overrun sticky, all other bits 0.
REQ-014 SHALL map offset 1 (0x80000004, read) to TX status: bit0 = TX FIFO not full, bit1 = TX overflow sticky, all other bits 0.
REQ-015 SHALL treat a read of TX status or RX status as clearing that register's sticky bit on the same edge; the returned value shows the bit before clearing.
REQ-016 SHALL map offset 2 (0x80000008, write) to TX data: push wdata into the TX FIFO if it is not full, else drop the byte and set the TX overflow sticky bit.
REQ-017 SHALL map offset 3 (0x8000000C, read) to RX data: pop the RX FIFO head and return {24'd0, byte}; if the FIFO is empty, return 0 with no pop.
REQ-018 SHALL treat reads of unmapped offsets as returning 0, and writes to read-only or unmapped offsets as no-ops.
REQ-019 SHALL update rdata one cycle after a decoded load and hold it otherwise, including while stall is high.
REQ-020 SHALL drive uart_din_valid = TX FIFO not empty and uart_din = TX head combinationally; a pop occurs on any edge with valid and uart_din_ready both high.
REQ-021 SHALL drive uart_dout_ready = RX FIFO not full; a push occurs on any edge with uart_dout_valid and uart_dout_ready both high.
REQ-022 SHALL set the RX overrun sticky bit when uart_dout_valid is high while the RX FIFO is full; that byte is lost.
REQ-023 SHALL allow a simultaneous push and pop on the same FIFO in one cycle, leaving occupancy unchanged; this applies even when the FIFO is full, with a CPU push to a full TX FIFO accepted only if a UART pop occurs on that same edge.
REQ-024 SHALL implement each FIFO with pointers of log2(FIFO_DEPTH)+1 bits that wrap modulo 2*FIFO_DEPTH; full = MSBs differ and the rest are equal, empty = pointers equal.
REQ-025 SHALL return bytes strictly in FIFO order, with no reordering and no duplication.

Reset
REQ-026 SHALL, on reset, clear both FIFO pointers and both sticky bits, and set rdata=0, uart_din_valid=0 and uart_dout_ready=1 (the FIFO is empty, not full) in the cycle after rst is sampled high.
REQ-027 SHALL make reset asserted mid-transfer discard all FIFO contents; no handshake completes on the reset edge.

Configuration
REQ-028 SHALL, when macro UART_MMIO_CYCLE_COUNTER_EN is defined, add a 32-bit free-running cycle counter readable at offset 4 (0x80000010); it wraps 0xFFFFFFFF to 0, is cleared by reset, and is cleared by any write to offset 6 (0x80000018).
REQ-029 SHALL, when UART_MMIO_CYCLE_COUNTER_EN is undefined, contain no counter logic, with offsets 4 and 6 behaving as unmapped.

Verification
REQ-030 SHALL cover this scenario: write 0x41, 0x42, 0x43 to 0x80000008 with uart_din_ready=1 -> uart_din presents 0x41, 0x42, 0x43 in order and valid drops after the third.
REQ-031 SHALL cover this scenario: uart_din_ready=0, 9 writes with FIFO_DEPTH=8 -> TX status reads 0x2 (not full=0, overflow=1), then 0x0 on a second read.
REQ-032 SHALL cover this scenario: UART pushes 0x55, then CPU reads 0x80000000 and 0x8000000C -> rdata=0x1, then 0x55; a further read of 0x8000000C returns 0.
REQ-033 SHALL cover this scenario: RX FIFO full, with a CPU pop of 0x8000000C and a UART push on the same edge -> occupancy stays 8, no overrun bit, and FIFO order is preserved.
REQ-034 SHALL cover this scenario: stall=1 during a write to 0x80000008 or a read of 0x8000000C -> FIFOs unchanged and rdata held.
REQ-035 SHALL cover this scenario: with UART_MMIO_CYCLE_COUNTER_EN, read 0x80000010 twice 10 cycles apart -> difference 10, and after a write to 0x80000018 the next read is a small value.
